aibio_cdr_phdet_filter: RTL and testbench
=========================================

# aibio_cdr_phdet_filter

Digital loop filter for the RX DLL clock-data-recovery path. It consumes the bang-bang phase-detector bit from the CDR phase sampler (one sample per clock, taken on the selected PI clock) and accumulates samples over a programmable window. It then makes a majority decision with a deadband and steps a circular phase-interpolator code up or down. It also reports lock once the loop dithers around the target phase.

## Interface
Parameters:
- WIN_MAX_W, 6, log2 of maximum vote window (64 samples)
- CODE_W, 7, PI code width; code space is circular (0..127)
- SETTLE_CYC, 4, cycles samples are ignored after a PI step
- LOCK_CNT, 8, qualifying windows required to assert lock

Ports:
- vddcq  input  1  supply; no functional effect in behavioural model
- vss  input  1  ground; no functional effect
- i_clk  input  1  filter clock; the PI clock used by the phase sampler
- i_reset  input  1  synchronous, active-high reset
- i_en  input  1  filter enable
- i_cdr_phdet  input  1  phase-detector sample (1 = PI clock late → step up)
- i_win_sel  input  3  window W = 2^(i_win_sel+1); values 5..7 give W = 64
- i_deadband  input  WIN_MAX_W  deadband margin, in samples
- o_pi_code  output  CODE_W  current PI code
- o_pi_up  output  1  one-cycle pulse, code incremented
- o_pi_dn  output  1  one-cycle pulse, code decremented
- o_lock  output  1  loop locked

## Operation
- FSM states: IDLE, ACCUM, DECIDE, SETTLE.
- IDLE:
  - Clears the sample counter and the ones counter.
  - Moves to ACCUM when i_en = 1.
- ACCUM:
  - W is latched from i_win_sel on entry.
  - On each cycle, adds i_cdr_phdet into n1 (WIN_MAX_W+1 bits, no overflow possible).
  - After W samples, moves to DECIDE.
- DECIDE evaluates n0 = W − n1, then:
  - If n1 ≥ W/2 + i_deadband + 1: UP; code ← code + 1 mod 2^CODE_W.
  - Else if n0 ≥ W/2 + i_deadband + 1: DN; code ← code − 1 mod 2^CODE_W.
  - Otherwise: HOLD.
  - Compare at WIN_MAX_W+2 bits so a large deadband cannot wrap. If the deadband is ≥ W/2, the result is always HOLD.
- Next state after DECIDE: SETTLE on UP/DN; ACCUM on HOLD.
- SETTLE:
  - Ignores i_cdr_phdet for SETTLE_CYC cycles, then moves to ACCUM.
- Lock counter (saturates at LOCK_CNT), updated in DECIDE:
  - Increments on HOLD, or on a step opposite to the previous step.
  - Clears on a step in the same direction as the previous step.
  - The first step after reset or enable counts as "same direction".
  - o_lock = (counter == LOCK_CNT).
- i_en deasserted in any state:
  - Next state is IDLE.
  - Counters, lock counter and lock are cleared.
  - o_pi_code is held.
  - A DECIDE in the same cycle is discarded: no pulse, no code change.
- i_reset:
  - Overrides everything at the next edge, including mid-window and mid-settle.
  - o_pi_code = 0, o_pi_up = 0, o_pi_dn = 0, o_lock = 0, FSM = IDLE.
- Wrap: the code wraps 2^CODE_W−1 → 0 on UP and 0 → 2^CODE_W−1 on DN, with no saturation.

## Timing
- All outputs are registered.
- The first sample is taken in the first ACCUM cycle. That cycle is one clock after the i_en rise, or one clock after leaving SETTLE.
- DECIDE takes 1 cycle. o_pi_up/o_pi_dn and the new o_pi_code appear together in the cycle after DECIDE; the pulse is exactly 1 cycle wide.
- o_lock updates in the same cycle as the pulse.
- Step loop period = W + 1 + SETTLE_CYC cycles. Hold loop period = W + 1 cycles.
- o_pi_up and o_pi_dn are never high together.

## Structure
- Shared package aibio_cdr_pkg holds:
  - the state enum (IDLE/ACCUM/DECIDE/SETTLE);
  - the decision enum (HOLD/UP/DN);
  - the default constants for WIN_MAX_W, CODE_W, SETTLE_CYC and LOCK_CNT.
- One sub-module, aibio_cdr_vote_acc: the window sample counter plus ones counter. It takes start/sample inputs and produces a done strobe and n1.
- The FSM, code register and lock logic live in the top module.

## Test plan
- Reset mid-ACCUM with i_cdr_phdet = 1, i_win_sel = 2 → the next cycle shows code 0, no pulses, o_lock = 0, and the FSM restarts only after a reset-free edge.
- i_win_sel = 2 (W = 8), deadband 0, constant 1 → o_pi_up pulses every 13 cycles; code goes 0→1→2. First pulse lands at cycle 10 after the i_en rise.
- W = 8, deadband 1, pattern of 5 ones and 3 zeros → HOLD (threshold 6). With deadband 0 → UP.
- Code at 127 with UP decisions → wraps to 0. Code at 0 with DN decisions → wraps to 127, with one o_pi_dn pulse.
- Alternating UP/DN windows (W = 4, all-ones then all-zeros) → o_lock rises on the 8th qualifying decision. A following repeated same-direction step drops it.
- i_en dropped in DECIDE → no pulse, code unchanged, FSM in IDLE next cycle, o_lock = 0.

Source files
------------

// File: rtl/aibio_cdr_pkg.sv
// aibio_cdr_pkg: shared types and default constants for the
// CDR bang-bang phase-detector loop filter.
package aibio_cdr_pkg;

  localparam int DEF_WIN_MAX_W  = 6;
  localparam int DEF_CODE_W     = 7;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_LOCK_CNT   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE,
    SETTLE
  } state_e;

  typedef enum logic [1:0] {
    HOLD,
    UP,
    DN
  } dec_e;

endpackage

// File: rtl/aibio_cdr_vote_acc.sv
// aibio_cdr_vote_acc: window sample counter and ones counter
// for the phase-detector majority vote.
module aibio_cdr_vote_acc
  import aibio_cdr_pkg::*;
#(
  parameter int WIN_MAX_W = DEF_WIN_MAX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sample,
  input  logic               phdet,
  input  logic [2:0]         win_sel,
  output logic               done,
  output logic [WIN_MAX_W:0] win,
  output logic [WIN_MAX_W:0] n1
);

  localparam logic [WIN_MAX_W:0] ONE = 1;

  logic [WIN_MAX_W:0] cnt;
  logic [WIN_MAX_W:0] win_dec;
  logic [3:0]         sh;

  // W = 2^(sel+1), clamped at the largest supported window
  always_comb begin
    sh = {1'b0, win_sel} + 4'd1;
    if (sh > 4'(WIN_MAX_W)) sh = 4'(WIN_MAX_W);
    win_dec = ONE << sh;
  end

  assign done = sample && (cnt == win - ONE);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      cnt <= '0;
      n1  <= '0;
    end else if (sample) begin
      cnt <= cnt + ONE;
      n1  <= n1 + {{WIN_MAX_W{1'b0}}, phdet};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) win <= '0;
    else if (start) win <= win_dec;
  end

endmodule

// File: rtl/aibio_cdr_phdet_filter.sv
// aibio_cdr_phdet_filter: vote-window loop filter that steps a
// circular PI code and reports lock when the loop dithers.
module aibio_cdr_phdet_filter
  import aibio_cdr_pkg::*;
#(
  parameter int WIN_MAX_W  = DEF_WIN_MAX_W,
  parameter int CODE_W     = DEF_CODE_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOCK_CNT   = DEF_LOCK_CNT
) (
  input  logic                 vddcq,
  input  logic                 vss,
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic                 i_cdr_phdet,
  input  logic [2:0]           i_win_sel,
  input  logic [WIN_MAX_W-1:0] i_deadband,
  output logic [CODE_W-1:0]    o_pi_code,
  output logic                 o_pi_up,
  output logic                 o_pi_dn,
  output logic                 o_lock
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [CODE_W-1:0] CODE_ONE = 1;

  state_e state, state_nxt;
  dec_e   dec;

  logic [SW-1:0]      scnt;
  logic [LW-1:0]      lcnt, lcnt_nxt;
  logic               prev_vld, prev_up;
  logic               start, sample, done;
  logic               step_up, step_dn, in_dec;
  logic [WIN_MAX_W:0] win, n1;
  logic [WIN_MAX_W+1:0] thr, n1x, n0x;
  logic               unused_supply;

  assign unused_supply = &{vddcq, vss};

  assign sample = i_en && (state == ACCUM);
  assign start  = !sample;

  aibio_cdr_vote_acc #(
    .WIN_MAX_W(WIN_MAX_W)
  ) u_vote (
    .clk    (i_clk),
    .reset  (i_reset),
    .start  (start),
    .sample (sample),
    .phdet  (i_cdr_phdet),
    .win_sel(i_win_sel),
    .done   (done),
    .win    (win),
    .n1     (n1)
  );

  // extra headroom bit so a large deadband cannot wrap
  assign thr = {2'b0, win[WIN_MAX_W:1]}
             + {2'b0, i_deadband}
             + {{(WIN_MAX_W+1){1'b0}}, 1'b1};
  assign n1x = {1'b0, n1};
  assign n0x = {1'b0, win - n1};

  always_comb begin
    dec = HOLD;
    if (n1x >= thr) dec = UP;
    else if (n0x >= thr) dec = DN;
  end

  assign in_dec  = i_en && (state == DECIDE);
  assign step_up = in_dec && (dec == UP);
  assign step_dn = in_dec && (dec == DN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_en) state_nxt = ACCUM;
      ACCUM:   if (done) state_nxt = DECIDE;
      DECIDE:  state_nxt = (dec == HOLD) ? ACCUM : SETTLE;
      SETTLE:  if (scnt == SW'(SETTLE_CYC - 1)) state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
    if (!i_en) state_nxt = IDLE;
  end

  // a reversal or a hold is evidence of dithering around lock
  always_comb begin
    lcnt_nxt = lcnt;
    if (!i_en) begin
      lcnt_nxt = '0;
    end else if (state == DECIDE) begin
      if (dec == HOLD || (prev_vld && prev_up != (dec == UP))) begin
        if (lcnt != LW'(LOCK_CNT)) lcnt_nxt = lcnt + LW'(1);
      end else begin
        lcnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      scnt      <= '0;
      lcnt      <= '0;
      prev_vld  <= 1'b0;
      prev_up   <= 1'b0;
      o_pi_code <= '0;
      o_pi_up   <= 1'b0;
      o_pi_dn   <= 1'b0;
      o_lock    <= 1'b0;
    end else begin
      state   <= state_nxt;
      scnt    <= (state == SETTLE) ? scnt + SW'(1) : '0;
      lcnt    <= lcnt_nxt;
      o_lock  <= (lcnt_nxt == LW'(LOCK_CNT));
      o_pi_up <= step_up;
      o_pi_dn <= step_dn;
      if (step_up) o_pi_code <= o_pi_code + CODE_ONE;
      else if (step_dn) o_pi_code <= o_pi_code - CODE_ONE;
      if (!i_en) begin
        prev_vld <= 1'b0;
      end else if (step_up || step_dn) begin
        prev_vld <= 1'b1;
        prev_up  <= step_up;
      end
    end
  end

endmodule

// File: tb/tb_aibio_cdr_phdet_filter.sv
// tb_aibio_cdr_phdet_filter: directed vectors with a loop-level
// reference model compared every cycle plus literal checks.
module tb_aibio_cdr_phdet_filter;

  localparam int SETTLE = 4;
  localparam int LOCKN  = 8;

  logic       clk = 1'b0;
  logic       vddcq, vss;
  logic       i_reset, i_en, i_cdr_phdet;
  logic [2:0] i_win_sel;
  logic [5:0] i_deadband;
  logic [6:0] o_pi_code;
  logic       o_pi_up, o_pi_dn, o_lock;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  aibio_cdr_phdet_filter dut (
    .vddcq      (vddcq),
    .vss        (vss),
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_en       (i_en),
    .i_cdr_phdet(i_cdr_phdet),
    .i_win_sel  (i_win_sel),
    .i_deadband (i_deadband),
    .o_pi_code  (o_pi_code),
    .o_pi_up    (o_pi_up),
    .o_pi_dn    (o_pi_dn),
    .o_lock     (o_lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int win_of(input logic [2:0] sel);
    return (sel >= 3'd5) ? 64 : (2 << sel);
  endfunction

  // loop-level reference: t counts cycles since the window opened
  int m_code, m_lc, m_last, m_t, m_w, m_ones, m_dir, m_thr;
  bit m_act, m_up, m_dn, m_lock;

  initial begin
    m_code = 0; m_lc = 0; m_last = 0; m_t = 0; m_w = 2; m_ones = 0;
    m_act = 0; m_up = 0; m_dn = 0; m_lock = 0;
  end

  always @(posedge clk) begin
    m_up = 0;
    m_dn = 0;
    if (i_reset) begin
      m_act = 0; m_code = 0; m_lc = 0; m_last = 0;
    end else if (!i_en) begin
      m_act = 0; m_lc = 0; m_last = 0;
    end else if (!m_act) begin
      m_act = 1; m_t = 0; m_ones = 0; m_w = win_of(i_win_sel);
    end else if (m_t < m_w) begin
      m_ones += int'(i_cdr_phdet);
      m_t++;
    end else if (m_t == m_w) begin
      m_thr = m_w / 2 + int'(i_deadband) + 1;
      if (m_ones >= m_thr) m_dir = 1;
      else if (m_w - m_ones >= m_thr) m_dir = -1;
      else m_dir = 0;
      if (m_dir == 0 || (m_last != 0 && m_dir != m_last))
        m_lc = (m_lc < LOCKN) ? m_lc + 1 : LOCKN;
      else
        m_lc = 0;
      if (m_dir != 0) begin
        m_last = m_dir;
        m_code = (m_code + m_dir + 128) % 128;
        m_up = (m_dir > 0);
        m_dn = (m_dir < 0);
        m_t++;
      end else begin
        m_t = 0; m_ones = 0; m_w = win_of(i_win_sel);
      end
    end else if (m_t == m_w + SETTLE) begin
      m_t = 0; m_ones = 0; m_w = win_of(i_win_sel);
    end else begin
      m_t++;
    end
    m_lock = (m_lc == LOCKN);
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("code", int'(o_pi_code), m_code);
      chk("up", int'(o_pi_up), int'(m_up));
      chk("dn", int'(o_pi_dn), int'(m_dn));
      chk("lock", int'(o_lock), int'(m_lock));
      chk("up_dn_excl", int'(o_pi_up && o_pi_dn), 0);
    end
  end

  int np, nd;
  bit lk [0:10];
  logic [7:0] pat;

  initial begin
    vddcq = 1'b1; vss = 1'b0;
    i_reset = 1'b1; i_en = 1'b0; i_cdr_phdet = 1'b0;
    i_win_sel = 3'd0; i_deadband = 6'd0;
    cyc(1);
    mon_on = 1'b1;
    cyc(1);
    chk("rst_code", int'(o_pi_code), 0);
    chk("rst_up", int'(o_pi_up), 0);
    chk("rst_dn", int'(o_pi_dn), 0);
    chk("rst_lock", int'(o_lock), 0);
    i_reset = 1'b0;

    // W=8 constant ones: pulses at cycles 10 and 23
    i_win_sel = 3'd2; i_cdr_phdet = 1'b1; i_en = 1'b1;
    np = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (o_pi_up) begin
        np++;
        if (np == 1) begin
          chk("t1_first_cyc", k, 10);
          chk("t1_code1", int'(o_pi_code), 1);
        end else if (np == 2) begin
          chk("t1_second_cyc", k, 23);
          chk("t1_code2", int'(o_pi_code), 2);
        end
      end
    end
    chk("t1_npulse", np, 2);

    // reset mid-window, then restart on a reset-free edge
    i_reset = 1'b1;
    cyc(1);
    chk("mid_rst_code", int'(o_pi_code), 0);
    chk("mid_rst_up", int'(o_pi_up), 0);
    chk("mid_rst_lock", int'(o_lock), 0);
    i_reset = 1'b0;
    np = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (o_pi_up && np == 0) begin
        np = 1;
        chk("rst_restart_cyc", k, 10);
        chk("rst_restart_code", int'(o_pi_code), 1);
      end
    end
    chk("rst_restart_seen", np, 1);
    i_en = 1'b0;
    cyc(2);

    // 5 ones / 3 zeros: hold with deadband 1, up with deadband 0
    pat = 8'b1011_0110;
    for (int d = 1; d >= 0; d--) begin
      i_deadband = 6'(d);
      i_en = 1'b1;
      cyc(1);
      for (int i = 0; i < 8; i++) begin
        i_cdr_phdet = pat[i];
        cyc(1);
      end
      cyc(1);
      chk(d == 1 ? "db1_up" : "db0_up", int'(o_pi_up), d == 1 ? 0 : 1);
      chk(d == 1 ? "db1_code" : "db0_code", int'(o_pi_code), d == 1 ? 1 : 2);
      i_en = 1'b0;
      cyc(2);
    end

    // wrap 0 -> 127 on DN, then 127 -> 0 on UP
    i_reset = 1'b1;
    cyc(1);
    i_reset = 1'b0;
    i_win_sel = 3'd0; i_deadband = 6'd0; i_cdr_phdet = 1'b0; i_en = 1'b1;
    nd = 0;
    cyc(4);
    if (o_pi_dn) nd++;
    chk("wrap_dn_pulse", int'(o_pi_dn), 1);
    chk("wrap_dn_code", int'(o_pi_code), 127);
    cyc(1);
    if (o_pi_dn) nd++;
    chk("wrap_dn_width", int'(o_pi_dn), 0);
    i_cdr_phdet = 1'b1;
    np = 0;
    for (int k = 0; k < 12 && np == 0; k++) begin
      cyc(1);
      if (o_pi_dn) nd++;
      if (o_pi_up) begin
        np = 1;
        chk("wrap_up_code", int'(o_pi_code), 0);
      end
    end
    chk("wrap_up_seen", np, 1);
    chk("wrap_dn_count", nd, 1);
    i_en = 1'b0;
    cyc(2);

    // alternating W=4 windows build lock, a repeat step drops it
    i_reset = 1'b1;
    cyc(1);
    i_reset = 1'b0;
    i_win_sel = 3'd1; i_cdr_phdet = 1'b1; i_en = 1'b1;
    np = 0;
    for (int c = 0; c < 150 && np < 10; c++) begin
      cyc(1);
      if (o_pi_up || o_pi_dn) begin
        np++;
        lk[np] = o_lock;
        i_cdr_phdet = (np < 9) ? o_pi_dn : 1'b1;
      end
    end
    chk("lock_npulse", np, 10);
    chk("lock_dec8", int'(lk[8]), 0);
    chk("lock_dec9", int'(lk[9]), 1);
    chk("lock_dec10", int'(lk[10]), 0);
    i_en = 1'b0;
    cyc(2);

    // enable dropped during DECIDE discards the step
    i_win_sel = 3'd0; i_cdr_phdet = 1'b1; i_en = 1'b1;
    cyc(3);
    i_en = 1'b0;
    cyc(1);
    chk("endrop_up", int'(o_pi_up), 0);
    chk("endrop_code", int'(o_pi_code), 2);
    chk("endrop_lock", int'(o_lock), 0);
    np = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      if (o_pi_up || o_pi_dn) np++;
    end
    chk("endrop_quiet", np, 0);
    i_en = 1'b1;
    np = 0;
    for (int k = 1; k <= 8 && np == 0; k++) begin
      cyc(1);
      if (o_pi_up) begin
        np = 1;
        chk("endrop_restart_cyc", k, 4);
        chk("endrop_restart_code", int'(o_pi_code), 3);
      end
    end
    chk("endrop_restart_seen", np, 1);
    i_en = 1'b0;
    cyc(2);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
